// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus definitions: request/response structs, burst length and
// transfer size encodings, and the grant index type used by arbiters.
//   CBUS_MAX_MASTERS : upper bound on masters one arbiter can serve
//   cbus_idx_t       : grant index, wide enough for CBUS_MAX_MASTERS
//   cbus_req_t       : master -> memory request (valid + burst descriptor)
//   cbus_resp_t      : memory -> master response beat (ready/last/data)
package cbus_arbiter_pkg;

   parameter int unsigned CBUS_MAX_MASTERS = 8;

   typedef logic [2:0]  cbus_idx_t;
   typedef logic [63:0] addr_t;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'b000,
      MSIZE2 = 3'b001,
      MSIZE4 = 3'b010,
      MSIZE8 = 3'b011
   } msize_t;

   // Encoded as (beats - 1) so it can double as a beat-count mask.
   typedef enum logic [3:0] {
      MLEN1  = 4'b0000,
      MLEN2  = 4'b0001,
      MLEN4  = 4'b0011,
      MLEN8  = 4'b0111,
      MLEN16 = 4'b1111
   } mlen_t;

   typedef struct packed {
      logic    valid;
      logic    is_write;
      msize_t  size;
      addr_t   addr;
      strobe_t strobe;
      word_t   data;
      mlen_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic  ready;
      logic  last;
      word_t data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin pick: rotated priority encoder over the valid vector.
// Scanning starts one past last_grant and wraps, so the most recently
// served master has the lowest priority.
//   valid      : per-master request valid
//   last_grant : index of the most recently granted master
//   found      : at least one master is requesting
//   pick       : index of the winning master (0 when found=0)
module rr_pick
   import cbus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0]         valid,
   input  logic [$clog2(NUM_MASTERS)-1:0] last_grant,
   output logic                           found,
   output logic [$clog2(NUM_MASTERS)-1:0] pick
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   int unsigned cand;

   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      // Offsets 1..NUM_MASTERS visit every master once, last_grant last.
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         cand = (32'(last_grant) + k) % NUM_MASTERS;
         if (!found && valid[cand]) begin
            found = 1'b1;
            pick  = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter from NUM_MASTERS CBus masters onto one memory-side
// CBus port. A grant is held for the whole burst and released on the beat
// with ready && last (or if the granted master drops valid). Every grant
// is preceded by one idle arbitration cycle, so grants never abut.
//   clk, reset : clock, synchronous active-high reset
//   ireqs      : requests from masters
//   iresps     : responses to masters (only the granted one is non-zero)
//   oreq       : request to memory side (pass-through of granted master)
//   oresp      : response from memory side
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireqs  [NUM_MASTERS],
   output cbus_resp_t iresps [NUM_MASTERS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   // IDLE/BUSY is the "busy" bit of the arbiter.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q, state_n;
   logic [IDX_W-1:0]   index_q, index_n;
   logic [IDX_W-1:0]   last_grant_q, last_grant_n;

   logic [NUM_MASTERS-1:0] valid_vec;
   logic                   found;
   logic [IDX_W-1:0]       pick;

   always_comb begin
      valid_vec = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         valid_vec[i] = ireqs[i].valid;
      end
   end

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .valid      (valid_vec),
      .last_grant (last_grant_q),
      .found      (found),
      .pick       (pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         index_q      <= '0;
         last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         state_q      <= state_n;
         index_q      <= index_n;
         last_grant_q <= last_grant_n;
      end
   end

   always_comb begin
      state_n      = state_q;
      index_n      = index_q;
      last_grant_n = last_grant_q;
      oreq         = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         iresps[i] = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_n = BUSY;
               index_n = pick;
            end
         end
         BUSY: begin
            oreq           = ireqs[index_q];
            iresps[index_q] = oresp;
            // A dropped valid mid-burst is treated as an early release.
            if (!ireqs[index_q].valid || (oresp.ready && oresp.last)) begin
               state_n      = IDLE;
               last_grant_n = index_q;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  ireqs  [2];
   cbus_resp_t iresps [2];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cbus_arbiter #(
      .NUM_MASTERS (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int m, input logic wr, input logic [63:0] addr,
                          input logic [63:0] data, input mlen_t len);
      ireqs[m]          = '0;
      ireqs[m].is_write = wr;
      ireqs[m].size     = MSIZE8;
      ireqs[m].addr     = addr;
      ireqs[m].data     = data;
      ireqs[m].strobe   = wr ? 8'hff : 8'h00;
      ireqs[m].len      = len;
      ireqs[m].valid    = 1'b1;
   endtask

   // Called in the first granted cycle; runs all beats, ends in the bubble.
   task automatic burst(input int m, input int nbeats, input logic [63:0] exp_addr,
                        input bit drop);
      check("grant_valid", oreq.valid, 1);
      check("grant_addr", oreq.addr, exp_addr);
      for (int k = 0; k < nbeats; k++) begin
         oresp.ready = 1'b1;
         oresp.last  = (k == nbeats - 1);
         oresp.data  = 64'ha000 + 64'(k);
         settle();
         check("beat_ready", iresps[m].ready, 1);
         check("beat_data", iresps[m].data, 64'ha000 + 64'(k));
         check("beat_last", iresps[m].last, (k == nbeats - 1) ? 1 : 0);
         check("other_ready", iresps[1-m].ready, 0);
         check("other_data", iresps[1-m].data, 0);
         check("busy_valid", oreq.valid, 1);
         cyc();
      end
      oresp = '0;
      if (drop) ireqs[m].valid = 1'b0;
      settle();
      check("bubble_valid", oreq.valid, 0);
   endtask

   initial begin
      reset    = 1'b1;
      ireqs[0] = '0;
      ireqs[1] = '0;
      oresp    = '0;
      cyc();
      cyc();
      reset = 1'b0;
      settle();
      check("rst_oreq_valid", oreq.valid, 0);
      check("rst_oreq_addr", oreq.addr, 0);
      check("rst_iresp0", iresps[0].ready, 0);

      // Priority after reset: master 0 first, then master 1 after a bubble.
      set_req(0, 1'b0, 64'h1000, 64'h0, MLEN4);
      set_req(1, 1'b0, 64'h2000, 64'h0, MLEN4);
      settle();
      check("idle_no_fwd", oreq.valid, 0);
      cyc();
      burst(0, 4, 64'h1000, 1'b1);
      cyc();
      burst(1, 4, 64'h2000, 1'b1);

      // Isolation: single write from master 1 (last_grant=1, scan wraps to 1).
      cyc();
      set_req(1, 1'b1, 64'h2100, 64'hdead_beef, MLEN1);
      settle();
      check("iso_idle", oreq.valid, 0);
      cyc();
      check("iso_data", oreq.data, 64'hdead_beef);
      check("iso_write", oreq.is_write, 1);
      check("iso_resp0_idle", iresps[0].data, 0);
      burst(1, 1, 64'h2100, 1'b1);

      // Fairness: both hold valid through 4 single-beat grants.
      set_req(0, 1'b0, 64'h3000, 64'h0, MLEN1);
      set_req(1, 1'b0, 64'h4000, 64'h0, MLEN1);
      for (int t = 0; t < 4; t++) begin
         cyc();
         burst(t % 2, 1, (t % 2 == 0) ? 64'h3000 : 64'h4000, 1'b0);
      end
      ireqs[0].valid = 1'b0;
      ireqs[1].valid = 1'b0;
      cyc();

      // Reset during beat 2 of an 8-beat read by master 1.
      set_req(1, 1'b0, 64'h5000, 64'h0, MLEN8);
      settle();
      cyc();
      check("rm_grant_addr", oreq.addr, 64'h5000);
      oresp.ready = 1'b1;
      oresp.data  = 64'hb001;
      cyc();
      oresp.data  = 64'hb002;
      reset       = 1'b1;
      settle();
      check("rm_beat2", iresps[1].data, 64'hb002);
      cyc();
      check("rm_oreq_valid", oreq.valid, 0);
      check("rm_oreq_addr", oreq.addr, 0);
      check("rm_discard", iresps[1].data, 0);
      check("rm_discard_rdy", iresps[1].ready, 0);
      reset = 1'b0;
      oresp = '0;
      set_req(0, 1'b0, 64'h6000, 64'h0, MLEN1);
      cyc();
      burst(0, 1, 64'h6000, 1'b1);
      ireqs[1].valid = 1'b0;
      cyc();

      // Valid dropped mid-burst by master 0; master 1 waiting.
      set_req(0, 1'b0, 64'h7000, 64'h0, MLEN4);
      settle();
      cyc();
      check("vd_grant", oreq.addr, 64'h7000);
      set_req(1, 1'b0, 64'h8000, 64'h0, MLEN1);
      oresp.ready = 1'b1;
      oresp.data  = 64'hc001;
      settle();
      check("vd_beat1", iresps[0].data, 64'hc001);
      cyc();
      oresp = '0;
      ireqs[0].valid = 1'b0;
      settle();
      check("vd_follow", oreq.valid, 0);
      cyc();
      check("vd_idle", oreq.valid, 0);
      cyc();
      burst(1, 1, 64'h8000, 1'b1);

      // Partial beats with ready gaps; master 1 requesting meanwhile.
      set_req(0, 1'b0, 64'h9000, 64'h0, MLEN4);
      settle();
      cyc();
      check("pb_grant", oreq.addr, 64'h9000);
      set_req(1, 1'b0, 64'ha100, 64'h0, MLEN1);
      for (int k = 0; k < 3; k++) begin
         oresp.ready = 1'b1;
         oresp.last  = 1'b0;
         oresp.data  = 64'hd000 + 64'(k);
         settle();
         check("pb_data", iresps[0].data, 64'hd000 + 64'(k));
         check("pb_other", iresps[1].ready, 0);
         cyc();
      end
      for (int k = 0; k < 2; k++) begin
         oresp = '0;
         settle();
         check("pb_hold", oreq.valid, 1);
         check("pb_hold_addr", oreq.addr, 64'h9000);
         check("pb_nordy", iresps[0].ready, 0);
         cyc();
      end
      oresp.ready = 1'b1;
      oresp.last  = 1'b1;
      oresp.data  = 64'hd0ff;
      settle();
      check("pb_last", iresps[0].last, 1);
      check("pb_last_other", iresps[1].last, 0);
      cyc();
      oresp = '0;
      ireqs[0].valid = 1'b0;
      settle();
      check("pb_bubble", oreq.valid, 0);
      cyc();
      burst(1, 1, 64'ha100, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
